fns_serial_encoder: RTL and testbench

FNS_SERIAL_ENCODER -- requirements
Module: fns_serial_encoder

---
 rtl/fns_serial_encoder.sv | 181 ++++++++++++++++++
 tb/tb_fns_serial_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_serial_encoder.sv
// fns_serial_encoder: serial encoder from an unsigned integer to a
// forbidden-transition-free (Fibonacci) codeword. One codeword bit is resolved
// per cycle, MSB first. Codeword bit k carries weight F(k+1), with F(1)=F(2)=1.
// Optional feature macro: FNS_RANGE_CHECK_EN adds input range checking (err).
//
// Handshake: both sides use valid/ready. A word moves only on a rising edge
// where valid and ready are both high. in_ready is high only in IDLE, and
// out_valid is high only in DONE. codeout and err hold steady from the rise of
// out_valid until the edge that accepts them.
module fns_serial_encoder #(
  parameter int CODE_W = 5,
  // F(n) = round(phi^n / sqrt(5)). The body checks this value against an exact
  // integer recurrence.
  localparam int DATA_W =
    $clog2(int'((1.6180339887498949 ** real'(CODE_W + 2)) / 2.2360679774997896))
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              busy,
  output logic              err
);

  function automatic int unsigned fib(input int k);
    int unsigned a, b, t;
    a = 1;
    b = 1;
    for (int n = 3; n <= k; n++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (k <= 0) ? 0 : b;
  endfunction

  localparam int IW = $clog2(CODE_W);
  localparam int TW = $clog2(CODE_W + 2);
  localparam int unsigned F_TOP = fib(CODE_W + 1);

  if (CODE_W < 3 || CODE_W > 24) begin : g_bad_code_w
    $error("fns_serial_encoder: CODE_W must be in 3..24");
  end
  if ($clog2(fib(CODE_W + 2)) != DATA_W) begin : g_bad_data_w
    $error("fns_serial_encoder: DATA_W does not match ceil(log2(F(CODE_W+2)))");
  end

  // Fibonacci weights F(0)..F(CODE_W+1), indexed by bit position.
  logic [31:0] fib_tab [CODE_W+2];
  for (genvar g = 0; g < CODE_W + 2; g++) begin : g_fib
    assign fib_tab[g] = 32'(fib(g));
  end

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] r, r_nx;
  logic [IW-1:0]     i, i_nx, i_up;
  logic [CODE_W-1:0] code, code_nx;
  logic [TW-1:0]     idx1, idx2;
  logic              bit_val;
  logic [31:0]       r_ext;

`ifdef FNS_RANGE_CHECK_EN
  localparam int unsigned F_LIM = fib(CODE_W + 2);
  logic err_q, err_nx;
  logic oor, oor_nx;
`endif

  assign r_ext = 32'(r);
  assign idx1  = TW'(i) + TW'(1);
  assign idx2  = TW'(i) + TW'(2);
  assign i_up  = i + IW'(1);

  // State register and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      i     <= '0;
      code  <= '0;
`ifdef FNS_RANGE_CHECK_EN
      err_q <= 1'b0;
      oor   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      r     <= r_nx;
      i     <= i_nx;
      code  <= code_nx;
`ifdef FNS_RANGE_CHECK_EN
      err_q <= err_nx;
      oor   <= oor_nx;
`endif
    end
  end

  // Next-state logic and the per-cycle bit decision.
  always_comb begin
    state_nx = state;
    r_nx     = r;
    i_nx     = i;
    code_nx  = code;
    bit_val  = 1'b0;
`ifdef FNS_RANGE_CHECK_EN
    err_nx   = err_q;
    oor_nx   = oor;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          r_nx     = datain;
          i_nx     = IW'(CODE_W - 1);
          code_nx  = '0;
          state_nx = ENC;
`ifdef FNS_RANGE_CHECK_EN
          err_nx   = 1'b0;
          oor_nx   = (32'(datain) >= F_LIM);
`endif
        end
      end
      ENC: begin
`ifdef FNS_RANGE_CHECK_EN
        if (oor) begin
          code_nx  = '0;
          err_nx   = 1'b1;
          oor_nx   = 1'b0;
          state_nx = DONE;
        end else
`endif
        begin
          // The MSB has no upper neighbour and bit 0 takes the leftover
          // remainder. Inner bits copy their upper neighbour when the remainder
          // sits in the ambiguous band [F(k+1), F(k+2)). That copy is what keeps
          // 010 and 101 out of the codeword.
          if (i == IW'(CODE_W - 1)) begin
            bit_val = (r_ext >= F_TOP);
          end else if (i == '0) begin
            bit_val = r[0];
          end else if (r_ext < fib_tab[idx1]) begin
            bit_val = 1'b0;
          end else if (r_ext >= fib_tab[idx2]) begin
            bit_val = 1'b1;
          end else begin
            bit_val = code[i_up];
          end
          code_nx[i] = bit_val;
          if (bit_val) begin
            r_nx = r - DATA_W'(fib_tab[idx1]);
          end
          if (i == '0) begin
            state_nx = DONE;
          end else begin
            i_nx = i - IW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ENC) || (state == DONE);
  assign codeout   = code;
`ifdef FNS_RANGE_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fns_serial_encoder.sv
// Testbench for fns_serial_encoder. It uses three instances: CODE_W=5 (main
// checks), CODE_W=3 (sweep) and CODE_W=8 (exhaustive run with random
// handshakes).
module tb_fns_serial_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // CODE_W = 5 instance (DATA_W = 4)
  logic       vld5, rdy5, ovld5, ordy5, busy5, err5;
  logic [3:0] din5;
  logic [4:0] code5;
  logic [5:0] exp_q5[$];

  // CODE_W = 3 instance (DATA_W = 3)
  logic       vld3, rdy3, ovld3, ordy3, busy3, err3;
  logic [2:0] din3;
  logic [2:0] code3;
  logic [2:0] exp_q3[$];

  // CODE_W = 8 instance (DATA_W = 6)
  logic       vld8, rdy8, ovld8, ordy8, busy8, err8;
  logic [5:0] din8;
  logic [7:0] code8;
  logic [5:0] exp_q8[$];

  fns_serial_encoder #(.CODE_W(5)) u_d5 (
    .clock(clk), .rst_n(rst_n), .in_valid(vld5), .in_ready(rdy5), .datain(din5),
    .out_valid(ovld5), .out_ready(ordy5), .codeout(code5), .busy(busy5), .err(err5)
  );

  fns_serial_encoder #(.CODE_W(3)) u_d3 (
    .clock(clk), .rst_n(rst_n), .in_valid(vld3), .in_ready(rdy3), .datain(din3),
    .out_valid(ovld3), .out_ready(ordy3), .codeout(code3), .busy(busy3), .err(err3)
  );

  fns_serial_encoder #(.CODE_W(8)) u_d8 (
    .clock(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8), .datain(din8),
    .out_valid(ovld8), .out_ready(ordy8), .codeout(code8), .busy(busy8), .err(err8)
  );

  function automatic int fib(input int k);
    int a, b, t;
    a = 1;
    b = 1;
    for (int n = 3; n <= k; n++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  // Sends one word into the CODE_W=5 instance and queues {err, codeout} as the
  // expected result. The task then checks the latency to out_valid, the popped
  // result, stability under back-pressure for 'hold' cycles, and the return to
  // IDLE. Stimulus on in_valid and out_ready is random while the word is in
  // flight; the DUT must ignore it.
  task automatic xfer5(input logic [3:0] din, input logic [5:0] exp_w,
                       input int lat, input int hold, input bit chk_code);
    int edges;
    logic [5:0] e;
    logic [4:0] held;
    @(negedge clk);
    n_checks++;
    if (rdy5 !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle5: got %b expected 1", rdy5);
    end
    vld5 = 1'b1;
    din5 = din;
    exp_q5.push_back(exp_w);
    @(negedge clk);
    edges = 0;
    n_checks++;
    if (busy5 !== 1'b1 || rdy5 !== 1'b0 || ovld5 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_accept5: busy=%b in_ready=%b out_valid=%b expected 1,0,0",
               busy5, rdy5, ovld5);
    end
    while (edges < 40) begin
      if (ovld5 === 1'b1) break;
      vld5  = 1'($urandom_range(0, 1));
      din5  = 4'($urandom_range(0, 15));
      ordy5 = 1'($urandom_range(0, 1));
      @(negedge clk);
      edges++;
    end
    vld5  = 1'b0;
    ordy5 = 1'b0;
    n_checks++;
    if (edges != lat) begin
      n_fail++;
      $display("FAIL latency5 din=%0d: got %0d edges expected %0d", din, edges, lat);
    end
    n_checks++;
    if (exp_q5.size() == 0) begin
      n_fail++;
      $display("FAIL queue5: got empty queue expected one entry");
      e = '0;
    end else begin
      e = exp_q5.pop_front();
      if (err5 !== e[5] || (chk_code && code5 !== e[4:0])) begin
        n_fail++;
        $display("FAIL codeout5 din=%0d: got err=%b code=%b expected err=%b code=%b",
                 din, err5, code5, e[5], e[4:0]);
      end
    end
    held = code5;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      n_checks++;
      if (ovld5 !== 1'b1 || rdy5 !== 1'b0 || code5 !== held || err5 !== e[5]) begin
        n_fail++;
        $display("FAIL hold5 cycle %0d: got out_valid=%b in_ready=%b code=%b expected 1,0,%b",
                 c, ovld5, rdy5, code5, held);
      end
    end
    ordy5 = 1'b1;
    @(negedge clk);
    ordy5 = 1'b0;
    n_checks++;
    if (ovld5 !== 1'b0 || rdy5 !== 1'b1 || busy5 !== 1'b0) begin
      n_fail++;
      $display("FAIL release5: got out_valid=%b in_ready=%b busy=%b expected 0,1,0",
               ovld5, rdy5, busy5);
    end
  endtask

  // Sends one word into the CODE_W=3 instance and checks latency and code.
  task automatic xfer3(input logic [2:0] din, input logic [2:0] exp_c);
    int edges;
    logic [2:0] e;
    @(negedge clk);
    vld3 = 1'b1;
    din3 = din;
    exp_q3.push_back(exp_c);
    @(negedge clk);
    vld3  = 1'b0;
    edges = 0;
    while (edges < 40 && ovld3 !== 1'b1) begin
      @(negedge clk);
      edges++;
    end
    n_checks++;
    if (edges != 3) begin
      n_fail++;
      $display("FAIL latency3 din=%0d: got %0d edges expected 3", din, edges);
    end
    e = (exp_q3.size() != 0) ? exp_q3.pop_front() : 3'bxxx;
    n_checks++;
    if (code3 !== e) begin
      n_fail++;
      $display("FAIL codeout3 din=%0d: got %b expected %b", din, code3, e);
    end
    ordy3 = 1'b1;
    @(negedge clk);
    ordy3 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ovld5 !== 1'b0 || busy5 !== 1'b0 || code5 !== 5'b0 || err5 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs5: got out_valid=%b busy=%b code=%b err=%b expected 0,0,00000,0",
               ovld5, busy5, code5, err5);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy5 !== 1'b1 || rdy3 !== 1'b1 || rdy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b%b%b expected 111", rdy5, rdy3, rdy8);
    end
  endtask

  task automatic test_encode_values();
    xfer5(4'd12, 6'b0_11111, 5, 0, 1'b1);
    xfer5(4'd6,  6'b0_01110, 5, 0, 1'b1);
    xfer5(4'd0,  6'b0_00000, 5, 0, 1'b1);
    xfer5(4'd3,  6'b0_00110, 5, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    xfer5(4'd6, 6'b0_01110, 5, 7, 1'b1);
  endtask

  task automatic test_range();
`ifdef FNS_RANGE_CHECK_EN
    xfer5(4'd13, 6'b1_00000, 1, 2, 1'b1);
`else
    xfer5(4'd13, 6'b0_00000, 5, 2, 1'b0);
`endif
    xfer5(4'd5, 6'b0_01100, 5, 0, 1'b1);
  endtask

  task automatic test_reset_mid_enc();
    bit saw_valid;
    @(negedge clk);
    vld5 = 1'b1;
    din5 = 4'd9;
    @(negedge clk);
    vld5 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ovld5 !== 1'b0 || busy5 !== 1'b0 || code5 !== 5'b0 || err5 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_enc: got out_valid=%b busy=%b code=%b err=%b expected 0,0,00000,0",
               ovld5, busy5, code5, err5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ovld5 === 1'b1) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL reset_discard: got out_valid=1 expected no output for discarded word");
    end
    xfer5(4'd6, 6'b0_01110, 5, 0, 1'b1);
  endtask

  task automatic test_cw3_sweep();
    logic [2:0] tab [5];
    tab = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b111};
    for (int v = 0; v < 5; v++) begin
      xfer3(3'(v), tab[v]);
    end
  endtask

  task automatic test_cw8_exhaustive();
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    fork
      begin : drv
        for (int v = 0; v < 55; v++) begin
          bit acc;
          int guard;
          acc = 1'b0;
          guard = 0;
          while (!acc && guard < 400) begin
            @(negedge clk);
            vld8 = 1'($urandom_range(0, 1));
            din8 = 6'(v);
            acc = vld8 && (rdy8 === 1'b1);
            if (acc) exp_q8.push_back(6'(v));
            guard++;
          end
        end
        @(negedge clk);
        vld8 = 1'b0;
      end
      begin : mon
        while (got < 55 && cyc < 20000) begin
          int sum;
          bit bad_pat;
          logic [5:0] e;
          @(negedge clk);
          cyc++;
          ordy8 = 1'($urandom_range(0, 1));
          if (ovld8 === 1'b1 && ordy8) begin
            got++;
            sum = 0;
            bad_pat = 1'b0;
            for (int k = 0; k < 8; k++) if (code8[k]) sum += fib(k + 1);
            for (int k = 0; k < 6; k++)
              if (code8[k +: 3] == 3'b010 || code8[k +: 3] == 3'b101) bad_pat = 1'b1;
            n_checks++;
            if (exp_q8.size() == 0) begin
              n_fail++;
              $display("FAIL cw8_extra_word: got code=%b expected no output", code8);
            end else begin
              e = exp_q8.pop_front();
              if (sum != int'(e) || bad_pat || err8 !== 1'b0) begin
                n_fail++;
                $display("FAIL cw8_word: got code=%b sum=%0d err=%b expected sum=%0d err=0 no 010/101",
                         code8, sum, err8, e);
              end
            end
          end
        end
        ordy8 = 1'b0;
      end
    join
    n_checks++;
    if (got != 55 || exp_q8.size() != 0) begin
      n_fail++;
      $display("FAIL cw8_count: got %0d words (%0d pending) expected 55 (0 pending)",
               got, exp_q8.size());
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vld5 = 1'b0; din5 = '0; ordy5 = 1'b0;
    vld3 = 1'b0; din3 = '0; ordy3 = 1'b0;
    vld8 = 1'b0; din8 = '0; ordy8 = 1'b0;
    test_reset();
    test_encode_values();
    test_backpressure();
    test_range();
    test_reset_mid_enc();
    test_cw3_sweep();
    test_cw8_exhaustive();
    n_checks++;
    if (exp_q5.size() != 0 || exp_q3.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d/%0d pending expected 0/0",
               exp_q5.size(), exp_q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
